// File: rtl/tinker_mem_responder.sv
// tinker_mem_responder
//   Multi-cycle, byte-addressed, little-endian memory for the Tinker core.
//   Serves an instruction-fetch port (32-bit reads) and a data port (64-bit
//   loads/stores). One transaction is held at a time; the response is strobed
//   LATENCY edges after acceptance. The data port has fixed priority.
//
// Parameters
//   MEM_SIZE : memory size in bytes (power of two)
//   LATENCY  : edges from acceptance to response (>= 1)
//
// Ports
//   clk, reset (asynchronous, active high)
//   if_req_valid/ready/addr, if_rsp_valid/data/err : fetch port
//   d_req_valid/ready/we/addr/wdata,
//   d_rsp_valid/data/err                           : data port
//
// Configuration macro
//   TINKER_MEM_ERR_EN : when defined, out-of-range accesses (and misaligned
//   fetches) return err=1 with zero data and suppress stores. When undefined,
//   the err outputs stay 0 and byte addresses wrap modulo MEM_SIZE.
module tinker_mem_responder #(
  parameter int MEM_SIZE = 524288,
  parameter int LATENCY  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_we,
  input  logic [31:0] d_req_addr,
  input  logic [63:0] d_req_wdata,
  output logic        d_rsp_valid,
  output logic [63:0] d_rsp_data,
  output logic        d_rsp_err
);

  localparam int AW = $clog2(MEM_SIZE);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  logic [7:0] bytes [0:MEM_SIZE-1];

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          port_d_q, port_d_d;   // 1 = data port owns the transaction
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;

  logic          if_rsp_valid_q, if_rsp_valid_d;
  logic [31:0]   if_rsp_data_q, if_rsp_data_d;
  logic          if_rsp_err_q, if_rsp_err_d;
  logic          d_rsp_valid_q, d_rsp_valid_d;
  logic [63:0]   d_rsp_data_q, d_rsp_data_d;
  logic          d_rsp_err_q, d_rsp_err_d;

  logic          fire;
  logic          mem_we;
  logic          if_err;
  logic          d_err;
  logic [63:0]   rd_data;
  logic [AW-1:0] byte_idx [8];

  // Byte i of the access lives at addr+i, wrapped to the memory size.
  for (genvar gi = 0; gi < 8; gi++) begin : g_bytes
    assign byte_idx[gi] = addr_q[AW-1:0] + AW'(gi);
    assign rd_data[8*gi +: 8] = bytes[byte_idx[gi]];
  end

`ifdef TINKER_MEM_ERR_EN
  // 33-bit compares so addresses near 2^32 do not wrap into range.
  assign d_err  = ({1'b0, addr_q} + 33'd7) >= 33'(MEM_SIZE);
  assign if_err = (addr_q[1:0] != 2'b00) ||
                  (({1'b0, addr_q} + 33'd3) >= 33'(MEM_SIZE));
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_q[31:AW];
  assign d_err  = 1'b0;
  assign if_err = 1'b0;
`endif

  assign d_req_ready  = (state_q == IDLE) && !reset;
  assign if_req_ready = (state_q == IDLE) && !reset && !d_req_valid;

  assign fire   = (state_q == BUSY) && (cnt_q == '0);
  assign mem_we = fire && port_d_q && we_q && !d_err && !reset;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    port_d_d       = port_d_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    if_rsp_valid_d = 1'b0;
    if_rsp_data_d  = if_rsp_data_q;
    if_rsp_err_d   = if_rsp_err_q;
    d_rsp_valid_d  = 1'b0;
    d_rsp_data_d   = d_rsp_data_q;
    d_rsp_err_d    = d_rsp_err_q;
    case (state_q)
      IDLE: begin
        if (d_req_valid && d_req_ready) begin
          state_d  = BUSY;
          cnt_d    = CW'(LATENCY - 1);
          port_d_d = 1'b1;
          we_d     = d_req_we;
          addr_d   = d_req_addr;
          wdata_d  = d_req_wdata;
        end else if (if_req_valid && if_req_ready) begin
          state_d  = BUSY;
          cnt_d    = CW'(LATENCY - 1);
          port_d_d = 1'b0;
          we_d     = 1'b0;
          addr_d   = if_req_addr;
          wdata_d  = '0;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (port_d_q) begin
            d_rsp_valid_d = 1'b1;
            d_rsp_err_d   = d_err;
            d_rsp_data_d  = (we_q || d_err) ? 64'd0 : rd_data;
          end else begin
            if_rsp_valid_d = 1'b1;
            if_rsp_err_d   = if_err;
            if_rsp_data_d  = if_err ? 32'd0 : rd_data[31:0];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      port_d_q       <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      if_rsp_err_q   <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
      d_rsp_data_q   <= '0;
      d_rsp_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      port_d_q       <= port_d_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      if_rsp_err_q   <= if_rsp_err_d;
      d_rsp_valid_q  <= d_rsp_valid_d;
      d_rsp_data_q   <= d_rsp_data_d;
      d_rsp_err_q    <= d_rsp_err_d;
    end
  end

  // Storage is never reset; a store lands on its response edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        bytes[byte_idx[i]] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_data  = if_rsp_data_q;
  assign if_rsp_err   = if_rsp_err_q;
  assign d_rsp_valid  = d_rsp_valid_q;
  assign d_rsp_data   = d_rsp_data_q;
  assign d_rsp_err    = d_rsp_err_q;

endmodule

// File: tb/tb_tinker_mem_responder.sv
module tb_tinker_mem_responder;
  localparam int MEM_SIZE = 524288;
  localparam int LATENCY  = 2;
`ifdef TINKER_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_valid, if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        if_rsp_err;
  logic        d_req_valid, d_req_ready, d_req_we;
  logic [31:0] d_req_addr;
  logic [63:0] d_req_wdata;
  logic        d_rsp_valid;
  logic [63:0] d_rsp_data;
  logic        d_rsp_err;

  int tests = 0;
  int fails = 0;

  // Reference memory image and last values seen on each response port.
  logic [7:0]  model [0:MEM_SIZE-1];
  logic [31:0] last_if_data;
  logic        last_if_err;
  logic [63:0] last_d_data;
  logic        last_d_err;

  tinker_mem_responder #(.MEM_SIZE(MEM_SIZE), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_req_addr(if_req_addr), .if_rsp_valid(if_rsp_valid),
    .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
    .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_rsp_valid(d_rsp_valid),
    .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mread(input logic [31:0] a, input int n);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = model[(a + 32'(i)) & 32'(MEM_SIZE - 1)];
    return r;
  endfunction

  function automatic bit d_err_exp(input logic [31:0] a);
    return ERR_EN && ((64'(a) + 64'd7) >= 64'(MEM_SIZE));
  endfunction

  function automatic bit f_err_exp(input logic [31:0] a);
    return ERR_EN && ((a[1:0] != 2'b00) || ((64'(a) + 64'd3) >= 64'(MEM_SIZE)));
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    model[a] = v;
    dut.bytes[a] = v;
  endtask

  // One complete transaction. With pre=1 the request is already being driven.
  task automatic xact(input bit is_d, input bit we, input logic [31:0] addr,
                      input logic [63:0] wdata, input bit pre);
    logic [63:0] exp_data;
    bit          exp_err;
    if (!pre) begin
      @(negedge clk);
      if (is_d) begin
        d_req_valid = 1'b1; d_req_we = we; d_req_addr = addr; d_req_wdata = wdata;
      end else begin
        if_req_valid = 1'b1; if_req_addr = addr;
      end
    end
    chk(is_d ? "d_ready_idle" : "if_ready_idle", is_d ? d_req_ready : if_req_ready, 1);
    @(posedge clk); #1;
    // Previous strobe is over and its data/err are held.
    chk("d_rsp_valid_after", d_rsp_valid, 0);
    chk("if_rsp_valid_after", if_rsp_valid, 0);
    chk("d_rsp_hold", {d_rsp_err, d_rsp_data}, {last_d_err, last_d_data});
    chk("if_rsp_hold", {if_rsp_err, if_rsp_data}, {last_if_err, last_if_data});
    chk("ready_busy", {d_req_ready, if_req_ready}, 0);
    if (is_d) begin
      exp_err  = d_err_exp(addr);
      exp_data = (we || exp_err) ? 64'd0 : mread(addr, 8);
      if (we && !exp_err)
        for (int i = 0; i < 8; i++) model[(addr + 32'(i)) & 32'(MEM_SIZE - 1)] = wdata[8*i +: 8];
    end else begin
      exp_err  = f_err_exp(addr);
      exp_data = exp_err ? 64'd0 : mread(addr, 4);
    end
    @(negedge clk);
    if (is_d) d_req_valid = 1'b0; else if_req_valid = 1'b0;
    for (int k = 1; k <= LATENCY; k++) begin
      @(posedge clk); #1;
      chk(is_d ? "d_rsp_valid" : "if_rsp_valid", is_d ? d_rsp_valid : if_rsp_valid, (k == LATENCY));
      chk("other_rsp_valid", is_d ? if_rsp_valid : d_rsp_valid, 0);
      chk("d_ready_lat", d_req_ready, (k == LATENCY));
      chk("if_ready_lat", if_req_ready, (k == LATENCY) && !d_req_valid);
      if (k == LATENCY) begin
        if (is_d) begin
          chk("d_rsp_data", d_rsp_data, exp_data);
          chk("d_rsp_err", d_rsp_err, exp_err);
          last_d_data = exp_data; last_d_err = exp_err;
        end else begin
          chk("if_rsp_data", if_rsp_data, exp_data);
          chk("if_rsp_err", if_rsp_err, exp_err);
          last_if_data = exp_data[31:0]; last_if_err = exp_err;
        end
      end
    end
    $display("[TB] %s %s addr=%h wdata=%h exp_data=%h exp_err=%0d",
             is_d ? "data" : "fetch", we ? "store" : "load ", addr, wdata, exp_data, exp_err);
  endtask

  initial begin
    logic [31:0] a;
    logic [63:0] w;
    reset = 1'b1;
    if_req_valid = 1'b0; if_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0;
    last_if_data = '0; last_if_err = 1'b0; last_d_data = '0; last_d_err = 1'b0;
    for (int i = 0; i < MEM_SIZE; i++) poke(32'(i), 8'($urandom));

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_ready", {d_req_ready, if_req_ready}, 0);
    chk("rst_valids", {d_rsp_valid, if_rsp_valid}, 0);
    chk("rst_d_out", {d_rsp_err, d_rsp_data}, 0);
    chk("rst_if_out", {if_rsp_err, if_rsp_data}, 0);
    reset = 1'b0;
    #1 chk("ready_after_rst", {d_req_ready, if_req_ready}, 2'b11);

    // Fetch, normal
    poke(32'h2000, 8'h78); poke(32'h2001, 8'h56); poke(32'h2002, 8'h34); poke(32'h2003, 8'h12);
    xact(0, 0, 32'h2000, 0, 0);
    chk("fetch_const", if_rsp_data, 64'h12345678);

    // Store then load, unaligned load
    xact(1, 1, 32'h100, 64'h0102030405060708, 0);
    chk("byte_0x100", dut.bytes[32'h100], 64'h08);
    xact(1, 0, 32'h100, 0, 0);
    chk("load_const", d_rsp_data, 64'h0102030405060708);
    poke(32'h108, 8'hAA);
    xact(1, 0, 32'h101, 0, 0);
    chk("load_unaligned", d_rsp_data, 64'hAA01020304050607);

    // Arbitration: both valid in IDLE, data wins, fetch follows
    @(negedge clk);
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h100; d_req_wdata = '0;
    if_req_valid = 1'b1; if_req_addr = 32'h2000;
    #1 chk("arb_if_ready", if_req_ready, 0);
    xact(1, 0, 32'h100, 0, 1);
    xact(0, 0, 32'h2000, 0, 1);

    // Range / alignment boundaries (expectations follow the build mode)
    xact(1, 0, 32'h7FFFC, 0, 0);
    xact(1, 1, 32'h7FFF9, 64'hDEADBEEFCAFEF00D, 0);
    xact(1, 0, 32'h7FFF8, 0, 0);
    xact(0, 0, 32'h2002, 0, 0);
    xact(0, 0, 32'h7FFFC, 0, 0);

    // Reset mid-transaction: store to 0x200 must be discarded
    @(negedge clk);
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h200; d_req_wdata = 64'h1122334455667788;
    @(posedge clk); #1;
    @(negedge clk); d_req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("midrst_ready", {d_req_ready, if_req_ready}, 0);
      chk("midrst_valid", {d_rsp_valid, if_rsp_valid}, 0);
      chk("midrst_d_out", {d_rsp_err, d_rsp_data}, 0);
      @(posedge clk); #1;
    end
    @(negedge clk); reset = 1'b0;
    #1 chk("release_d_ready", d_req_ready, 1);
    last_if_data = '0; last_if_err = 1'b0; last_d_data = '0; last_d_err = 1'b0;
    for (int k = 0; k < LATENCY + 2; k++) begin
      @(posedge clk); #1;
      chk("no_rsp_after_rst", {d_rsp_valid, if_rsp_valid}, 0);
    end
    for (int i = 0; i < 8; i++) chk("byte_0x200_kept", dut.bytes[32'h200 + i], model[32'h200 + i]);
    $display("[TB] reset during store to 00000200");
    xact(1, 0, 32'h200, 0, 0);

    // Randomized traffic over a small window plus the top of memory
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'(MEM_SIZE - 16) + 32'($urandom_range(0, 15))
                                      : 32'h3000 + 32'($urandom_range(0, 63));
      w = {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0: xact(1, 1, a, w, 0);
        1: xact(1, 0, a, 0, 0);
        default: xact(0, 0, ($urandom_range(0, 4) == 0) ? a : (a & ~32'h3), 0, 0);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: observed no end expected finish");
    $fatal(1, "timeout");
  end
endmodule
